// File: rtl/montgomery_digit_ctrl.sv
// Sequencing controller for the radix-4 Montgomery multiplication loop.
// Loads operand A into the shift register, then for every 2-bit digit:
// starts the adder with the digit as multiple select, waits for it,
// shifts by 2 and waits out the shift-register latency.
module montgomery_digit_ctrl #(
    parameter int N_BITS    = 1024,
    parameter int ITER      = N_BITS / 2,
    parameter int SHIFT_LAT = 2,
    parameter int CW        = $clog2(ITER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          sr_enable,
    output logic          sr_shift,
    input  logic          sr_shift_done,
    input  logic [1:0]    digit,
    output logic          add_start,
    output logic [1:0]    add_sel,
    input  logic          add_done,
    output logic [CW-1:0] iter
);

    localparam int LW = $clog2(SHIFT_LAT + 1);
    localparam logic [CW-1:0] ITER_LAST = CW'(ITER - 1);
    localparam logic [LW-1:0] LAT_INIT  = LW'(SHIFT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_WAIT_ADD,
        S_SHIFT,
        S_WAIT_SHIFT,
        S_FINISH
    } state_t;

    state_t        state, state_nx;
    logic [LW-1:0] lat_cnt;
    logic [CW-1:0] iter_q;
    logic [1:0]    sel_q;
    logic          err_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and Moore pulse decode
    always_comb begin
        state_nx  = state;
        sr_enable = 1'b0;
        sr_shift  = 1'b0;
        add_start = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                sr_enable = 1'b1;
                state_nx  = S_ADD;
            end
            S_ADD: begin
                add_start = 1'b1;
                state_nx  = S_WAIT_ADD;
            end
            S_WAIT_ADD: begin
                if (add_done) state_nx = (iter_q == ITER_LAST) ? S_FINISH : S_SHIFT;
            end
            S_SHIFT: begin
                sr_shift = 1'b1;
                state_nx = S_WAIT_SHIFT;
            end
            S_WAIT_SHIFT: begin
                if (lat_cnt == LW'(1)) state_nx = S_ADD;
            end
            S_FINISH: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Iteration counter, digit capture, latency counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        iter_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_ADD:   sel_q   <= digit;
                S_SHIFT: lat_cnt <= LAT_INIT;
                S_WAIT_SHIFT: begin
                    lat_cnt <= lat_cnt - LW'(1);
                    if (lat_cnt == LW'(1)) begin
                        iter_q <= iter_q + CW'(1);
                        // A missing shift_done is recorded but never stalls the loop
                        if (!sr_shift_done) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The digit is passed straight through during ADD so the adder sees it
    // with add_start; the captured copy holds it until the next ADD.
    assign add_sel = (state == S_ADD) ? digit : sel_q;
    assign busy    = (state != S_IDLE);
    assign err     = err_q;
    assign iter    = iter_q;

endmodule

// File: tb/tb_montgomery_digit_ctrl.sv
// Directed bench for montgomery_digit_ctrl with simple adder and
// shift-register models driven from the controller's pulses.
module tb_montgomery_digit_ctrl;

    localparam int N_BITS = 1024;
    localparam int ITER   = 512;
    localparam int CW     = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err, sr_enable, sr_shift, add_start;
    logic          sr_shift_done, add_done;
    logic [1:0]    digit, add_sel;
    logic [CW-1:0] iter;

    int n_cmp = 0;
    int n_bad = 0;

    // model controls
    int stall_iter = -1;
    bit kill_en    = 1'b0;
    bit stray_en   = 1'b0;

    logic [3:0]        acnt = '0;
    logic [1:0]        sh_pipe = '0;
    logic [N_BITS-1:0] sreg = '0;
    logic [N_BITS-1:0] pat;

    always #5 clk = ~clk;

    montgomery_digit_ctrl #(.N_BITS(N_BITS)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .err(err), .sr_enable(sr_enable), .sr_shift(sr_shift),
        .sr_shift_done(sr_shift_done), .digit(digit), .add_start(add_start),
        .add_sel(add_sel), .add_done(add_done), .iter(iter)
    );

    // Adder: done 1 cycle after add_start (10 in the stalled step);
    // shift register: loads on sr_enable, shifts 2 cycles after sr_shift
    always_ff @(posedge clk) begin
        if (add_start)      acnt <= (int'(iter) == stall_iter) ? 4'd10 : 4'd1;
        else if (acnt != 0) acnt <= acnt - 4'd1;
        sh_pipe <= {sh_pipe[0], sr_shift};
        if (sr_enable)       sreg <= pat;
        else if (sh_pipe[1]) sreg <= sreg >> 2;
    end

    assign add_done      = (acnt == 4'd1) | (stray_en & (sr_shift | sh_pipe[0]));
    assign sr_shift_done = sh_pipe[1] & ~(kill_en && int'(iter) == 6);
    assign digit         = sreg[1:0];

    wire [31:0] outs = {15'd0, busy, done, err, sr_enable, sr_shift, add_start, add_sel, iter};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full multiplication; start is applied before the next edge (cycle 0)
    task automatic run_op(input int stall, input bit kill, input bit stray,
                          input bit noise, input int exp_done);
        int cyc, dcyc, nadd, nsh, selbad, ohbad, errany, last;
        logic e36, e37, edone;
        stall_iter = stall; kill_en = kill; stray_en = stray;
        dcyc = -1; nadd = 0; nsh = 0; selbad = 0; ohbad = 0; errany = 0; last = 0;
        e36 = 1'bx; e37 = 1'bx; edone = 1'bx;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_pulse", sr_enable, 1);
        chk("iter_clear", iter, 0);
        chk("err_clear", err, 0);
        cyc = 1;
        while (dcyc < 0 && cyc < 4000) begin
            if (noise) start = (cyc == 50 || cyc == 51 || cyc == 300);
            if (int'(sr_enable) + int'(sr_shift) + int'(add_start) > 1) ohbad++;
            if (add_start) begin
                if (int'(add_sel) != ((nadd + 3) & 3) || int'(iter) != nadd) selbad++;
                last = (nadd + 3) & 3;
                nadd++;
            end else if (nadd > 0 && int'(add_sel) != last) selbad++;
            if (sr_shift) nsh++;
            if (err) errany++;
            if (cyc == 36) e36 = err;
            if (cyc == 37) e37 = err;
            if (done) begin
                dcyc  = cyc;
                edone = err;
                chk("busy_at_done", busy, 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_cycle", dcyc, exp_done);
        chk("busy_fall", busy, 0);
        chk("add_starts", nadd, ITER);
        chk("shifts", nsh, ITER - 1);
        chk("add_sel_seq", selbad, 0);
        chk("pulse_onehot", ohbad, 0);
        if (kill) begin
            chk("err_before", e36, 0);
            chk("err_set", e37, 1);
            chk("err_at_done", edone, 1);
        end else begin
            chk("err_quiet", errany, 0);
        end
        stall_iter = -1; kill_en = 1'b0; stray_en = 1'b0;
    endtask

    initial begin
        int bad, dn, found;
        pat = {128{8'h93}};   // digit sequence 3,0,1,2,...

        // reset with start high, then idle
        reset = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs, 0);
        reset = 1'b0; start = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (outs !== 32'd0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // nominal, then shift error back-to-back, then stall + stray add_done
        run_op(-1, 1'b0, 1'b0, 1'b0, 2559);
        run_op(-1, 1'b1, 1'b0, 1'b0, 2559);
        run_op(4,  1'b0, 1'b1, 1'b0, 2568);

        // abort in WAIT_ADD of step 100
        dn = 0; found = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (add_start && int'(iter) == 99) begin
                found = 1;
                break;
            end
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("abort_reach", found, 1);
        @(posedge clk); #1;
        chk("abort_in_wait", {busy, add_start, sr_shift}, 3'b100);
        reset = 1'b1;
        @(posedge clk); #1;
        if (done) dn++;
        chk("abort_outs", outs, 0);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        run_op(-1, 1'b0, 1'b0, 1'b1, 2559);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
